// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
//   statetype_t : main FSM states (LINK only reachable with MC_CTRL_BL_EN)
//   alu_sel_t   : which source the FSM asks the ALU decoder to use
//   OP_* / CMD_* / ALU_* / COND_* : instruction field and ALUControl encodings
//   cond_eval() : ARM condition evaluation against NZCV
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBranch,
        StLink
    } statetype_t;

    // ALU operation source requested by the FSM in the current state.
    typedef enum logic [1:0] {
        AluSelAdd,  // fixed ADD (PC arithmetic)
        AluSelDp,   // decoded from the data-processing cmd field
        AluSelMem   // ADD/SUB from the U bit for address offsets
    } alu_sel_t;

    // Op field, Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Data-processing cmd field, Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ALUControl encodings (truncated to ALUCTL_W at the top level)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    // Condition codes, Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Flags are packed {N, Z, C, V}.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic ex;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: ex = z;
            COND_NE: ex = ~z;
            COND_CS: ex = c;
            COND_CC: ex = ~c;
            COND_MI: ex = n;
            COND_PL: ex = ~n;
            COND_VS: ex = v;
            COND_VC: ex = ~v;
            COND_HI: ex = c & ~z;
            COND_LS: ex = ~c | z;
            COND_GE: ex = (n == v);
            COND_LT: ex = (n != v);
            COND_GT: ex = ~z & (n == v);
            COND_LE: ex = z | (n != v);
            COND_AL: ex = 1'b1;
            default: ex = 1'b0;  // 1111 never executes
        endcase
        return ex;
    endfunction

endpackage

// File: rtl/mc_main_fsm.sv
// Main Moore FSM of the multicycle controller: state register, next-state logic
// and the raw (ungated) per-state datapath controls.
// Optional feature macro: MC_CTRL_BL_EN (adds the LINK state for BL).
// Ports:
//   i_clk, i_reset      clock, synchronous active-low reset
//   i_op                Instr[27:26]
//   i_funct_i           Instr[25] (immediate operand)
//   i_funct_l           Instr[20] (load/store L bit)
//   i_link              Instr[24] (BL link bit)
//   o_pc_write_fetch    PC+4 load in FETCH (never condition-gated)
//   o_branch            PC load in BRANCH (gated by CondQ at the top)
//   o_ir_write          instruction register load
//   o_mem_write         raw memory write enable
//   o_reg_write_mem     raw register write from memory data
//   o_reg_write_alu     raw register write from ALUOut
//   o_link_write        raw R14 link write
//   o_adr_src, o_alu_src_a, o_alu_src_b, o_result_src   datapath mux selects
//   o_alu_sel           ALU op source for the top-level decoder
//   o_flag_stage        current state may update the flags
//   o_cond_latch        current state is DECODE (CondQ captures CondEx)
module mc_main_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_op,
    input  logic       i_funct_i,
    input  logic       i_funct_l,
    input  logic       i_link,
    output logic       o_pc_write_fetch,
    output logic       o_branch,
    output logic       o_ir_write,
    output logic       o_mem_write,
    output logic       o_reg_write_mem,
    output logic       o_reg_write_alu,
    output logic       o_link_write,
    output logic       o_adr_src,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_result_src,
    output alu_sel_t   o_alu_sel,
    output logic       o_flag_stage,
    output logic       o_cond_latch
);

    statetype_t r_state;
    statetype_t w_next_state;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifndef MC_CTRL_BL_EN
    logic w_unused_link;
    assign w_unused_link = i_link;
`endif

    always_comb begin
        w_next_state     = StFetch;
        o_pc_write_fetch = 1'b0;
        o_branch         = 1'b0;
        o_ir_write       = 1'b0;
        o_mem_write      = 1'b0;
        o_reg_write_mem  = 1'b0;
        o_reg_write_alu  = 1'b0;
        o_link_write     = 1'b0;
        o_adr_src        = 1'b0;
        o_alu_src_a      = 1'b0;
        o_alu_src_b      = 2'b00;
        o_result_src     = 2'b00;
        o_alu_sel        = AluSelAdd;
        o_flag_stage     = 1'b0;
        o_cond_latch     = 1'b0;

        case (r_state)
            StFetch: begin
                w_next_state     = StDecode;
                o_ir_write       = 1'b1;
                o_pc_write_fetch = 1'b1;
                o_alu_src_a      = 1'b1;
                o_alu_src_b      = 2'b10;
                o_result_src     = 2'b10;
            end
            StDecode: begin
                // PC+8 is presented on ResultSrc so R15 reads see it.
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_cond_latch = 1'b1;
                case (i_op)
                    OP_MEM:  w_next_state = StMemAdr;
                    OP_DP:   w_next_state = i_funct_i ? StExecuteI : StExecuteR;
                    OP_BR:   w_next_state = StBranch;
                    default: w_next_state = StFetch;
                endcase
            end
            StMemAdr: begin
                w_next_state = i_funct_l ? StMemRd : StMemWr;
                o_alu_src_a  = 1'b0;
                o_alu_src_b  = 2'b01;
                o_alu_sel    = AluSelMem;
            end
            StMemRd: begin
                w_next_state = StMemWb;
                o_adr_src    = 1'b1;
            end
            StMemWb: begin
                w_next_state    = StFetch;
                o_result_src    = 2'b01;
                o_reg_write_mem = 1'b1;
            end
            StMemWr: begin
                w_next_state = StFetch;
                o_adr_src    = 1'b1;
                o_mem_write  = 1'b1;
            end
            StExecuteR: begin
                w_next_state = StAluWb;
                o_alu_src_b  = 2'b00;
                o_alu_sel    = AluSelDp;
                o_flag_stage = 1'b1;
            end
            StExecuteI: begin
                w_next_state = StAluWb;
                o_alu_src_b  = 2'b01;
                o_alu_sel    = AluSelDp;
                o_flag_stage = 1'b1;
            end
            StAluWb: begin
                w_next_state    = StFetch;
                o_result_src    = 2'b00;
                o_reg_write_alu = 1'b1;
            end
            StBranch: begin
`ifdef MC_CTRL_BL_EN
                w_next_state = i_link ? StLink : StFetch;
`else
                w_next_state = StFetch;
`endif
                o_alu_src_a  = 1'b0;
                o_alu_src_b  = 2'b01;
                o_result_src = 2'b10;
                o_branch     = 1'b1;
            end
`ifdef MC_CTRL_BL_EN
            StLink: begin
                w_next_state = StFetch;
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_link_write = 1'b1;
            end
`endif
            default: w_next_state = StFetch;
        endcase

        // While reset is low nothing may be written and the muxes sit at FETCH values.
        if (!i_reset) begin
            w_next_state     = StFetch;
            o_pc_write_fetch = 1'b0;
            o_branch         = 1'b0;
            o_ir_write       = 1'b0;
            o_mem_write      = 1'b0;
            o_reg_write_mem  = 1'b0;
            o_reg_write_alu  = 1'b0;
            o_link_write     = 1'b0;
            o_adr_src        = 1'b0;
            o_alu_src_a      = 1'b1;
            o_alu_src_b      = 2'b10;
            o_result_src     = 2'b10;
            o_alu_sel        = AluSelAdd;
            o_flag_stage     = 1'b0;
            o_cond_latch     = 1'b0;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM plus ALU decoder, registered condition
// logic (CondQ) and the NZCV flag register.
// Optional feature macro: MC_CTRL_BL_EN (BL writes PC+4 to R14 via a LINK state).
// Ports:
//   i_clk, i_reset   clock, synchronous active-low reset
//   i_instr          Instr[31:12] from the IR
//   i_alu_flags      NZCV from the ALU this cycle
//   o_pc_write, o_adr_src, o_mem_write, o_ir_write, o_result_src, o_alu_src_a,
//   o_alu_src_b, o_alu_control, o_imm_src, o_reg_src, o_reg_write, o_link_write
//                    multicycle datapath controls
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTL_W = 2,
    parameter int unsigned FLAG_W   = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [19:0]         i_instr,
    input  logic [FLAG_W-1:0]   i_alu_flags,
    output logic                o_pc_write,
    output logic                o_adr_src,
    output logic                o_mem_write,
    output logic                o_ir_write,
    output logic [1:0]          o_result_src,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [ALUCTL_W-1:0] o_alu_control,
    output logic [1:0]          o_imm_src,
    output logic [1:0]          o_reg_src,
    output logic                o_reg_write,
    output logic                o_link_write
);

    if (FLAG_W != 4) begin : g_bad_flag_w
        $error("mc_controller: FLAG_W must be 4");
    end
    if (ALUCTL_W != 2 && ALUCTL_W != 3) begin : g_bad_aluctl_w
        $error("mc_controller: ALUCTL_W must be 2 or 3");
    end

    // i_instr holds Instr[31:12]; bit k here is Instr[k+12].
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_funct_i;
    logic [3:0] w_cmd;
    logic       w_s_bit;
    logic       w_u_bit;
    logic       w_link_bit;

    assign w_cond     = i_instr[19:16];
    assign w_op       = i_instr[15:14];
    assign w_funct_i  = i_instr[13];
    assign w_cmd      = i_instr[12:9];
    assign w_u_bit    = i_instr[11];
    assign w_s_bit    = i_instr[8];  // S for data-processing, L for memory
    assign w_link_bit = i_instr[12];

    logic       w_pc_write_fetch;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_reg_write_mem;
    logic       w_reg_write_alu;
    logic       w_link_write;
    alu_sel_t   w_alu_sel;
    logic       w_flag_stage;
    logic       w_cond_latch;

    mc_main_fsm u_main_fsm (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_op             (w_op),
        .i_funct_i        (w_funct_i),
        .i_funct_l        (w_s_bit),
        .i_link           (w_link_bit),
        .o_pc_write_fetch (w_pc_write_fetch),
        .o_branch         (w_branch),
        .o_ir_write       (o_ir_write),
        .o_mem_write      (w_mem_write),
        .o_reg_write_mem  (w_reg_write_mem),
        .o_reg_write_alu  (w_reg_write_alu),
        .o_link_write     (w_link_write),
        .o_adr_src        (o_adr_src),
        .o_alu_src_a      (o_alu_src_a),
        .o_alu_src_b      (o_alu_src_b),
        .o_result_src     (o_result_src),
        .o_alu_sel        (w_alu_sel),
        .o_flag_stage     (w_flag_stage),
        .o_cond_latch     (w_cond_latch)
    );

    // ALU decoder. Unsupported cmds compute ADD but never write back.
    logic [2:0] w_dp_ctl;
    logic       w_no_write;
    logic [2:0] w_alu_ctl;
    logic       w_add_sub;

    always_comb begin
        w_dp_ctl   = ALU_ADD;
        w_no_write = 1'b0;
        case (w_cmd)
            CMD_ADD: w_dp_ctl = ALU_ADD;
            CMD_SUB: w_dp_ctl = ALU_SUB;
            CMD_AND: w_dp_ctl = ALU_AND;
            CMD_ORR: w_dp_ctl = ALU_ORR;
            CMD_CMP: begin
                w_dp_ctl   = ALU_SUB;
                w_no_write = 1'b1;
            end
            CMD_EOR: begin
                if (ALUCTL_W >= 3) begin
                    w_dp_ctl = ALU_EOR;
                end else begin
                    w_no_write = 1'b1;
                end
            end
            default: w_no_write = 1'b1;
        endcase
    end

    always_comb begin
        w_alu_ctl = ALU_ADD;
        case (w_alu_sel)
            AluSelDp:  w_alu_ctl = w_dp_ctl;
            AluSelMem: w_alu_ctl = w_u_bit ? ALU_ADD : ALU_SUB;
            default:   w_alu_ctl = ALU_ADD;
        endcase
    end

    assign w_add_sub     = (w_dp_ctl == ALU_ADD) || (w_dp_ctl == ALU_SUB);
    assign o_alu_control = w_alu_ctl[ALUCTL_W-1:0];

    // Condition logic: evaluated in DECODE against the registered flags.
    logic [3:0] r_flags;
    logic       r_cond_q;
    logic       w_cond_ex;

    assign w_cond_ex = cond_eval(w_cond, r_flags);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_flags  <= '0;
            r_cond_q <= 1'b0;
        end else begin
            if (w_cond_latch) begin
                r_cond_q <= w_cond_ex;
            end
            if (w_flag_stage && w_s_bit && r_cond_q) begin
                r_flags[3:2] <= i_alu_flags[3:2];  // N, Z
                if (w_add_sub) begin
                    r_flags[1:0] <= i_alu_flags[1:0];  // C, V
                end
            end
        end
    end

    // FETCH's PC increment is unconditional; every other write waits on CondQ.
    assign o_pc_write   = w_pc_write_fetch | (w_branch & r_cond_q);
    assign o_mem_write  = w_mem_write & r_cond_q;
    assign o_reg_write  = (w_reg_write_mem | (w_reg_write_alu & ~w_no_write)) & r_cond_q;
    assign o_link_write = w_link_write & r_cond_q;

    assign o_imm_src = w_op;
    assign o_reg_src = {w_op == OP_MEM, w_op == OP_BR};

    logic w_unused;
    assign w_unused = ^{i_instr[7:0], w_alu_ctl[2]};

endmodule
